// File: rtl/ibex_mem_arb_pkg.sv
// Shared types and helpers for the ibex memory-port arbiter.
package ibex_mem_arb_pkg;

   typedef enum logic {
      ARB_IDLE   = 1'b0,
      ARB_LOCKED = 1'b1
   } arb_state_e;

   function automatic int ID_W(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   // Requesters above NUM_REQ are zero, so a mod-8 search equals a mod-NUM_REQ search.
   function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr);
      logic [2:0] idx;
      rr_pick = ptr;
      for (int i = 7; i >= 0; i--) begin
         idx = ptr + 3'(i);
         if (req[idx]) rr_pick = idx;
      end
   endfunction

endpackage

// File: rtl/ibex_mem_arb_id_fifo.sv
// In-order ID FIFO, DEPTH entries; rdata shows the head, full/empty are registered-pointer derived.
module ibex_mem_arb_id_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW:0]      wptr;
   logic [AW:0]      rptr;

   assign empty = (wptr == rptr);
   assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
   assign rdata = mem[rptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (push && !full) mem[wptr[AW-1:0]] <= wdata;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wptr <= '0;
         rptr <= '0;
      end else begin
         if (push && !full) wptr <= wptr + (AW+1)'(1);
         if (pop && !empty) rptr <= rptr + (AW+1)'(1);
      end
   end

endmodule

// File: rtl/ibex_mem_arbiter.sv
// N-host ibex memory-port arbiter: zero-latency grant, in-order response routing via ID FIFO.
// Stalled address phases lock the selection; a full FIFO drops m_req_o. IBEX_MEM_ARB_FIXED_PRIO_EN selects fixed priority.
module ibex_mem_arbiter
   import ibex_mem_arb_pkg::*;
#(
   parameter int NUM_REQ         = 2,
   parameter int ADDR_WIDTH      = 32,
   parameter int DATA_WIDTH      = 32,
   parameter int MAX_OUTSTANDING = 4
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic [NUM_REQ-1:0]              h_req_i,
   output logic [NUM_REQ-1:0]              h_gnt_o,
   input  logic [NUM_REQ*ADDR_WIDTH-1:0]   h_addr_i,
   input  logic [NUM_REQ-1:0]              h_we_i,
   input  logic [NUM_REQ*DATA_WIDTH/8-1:0] h_be_i,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   h_wdata_i,
   output logic [NUM_REQ-1:0]              h_rvalid_o,
   output logic [NUM_REQ*DATA_WIDTH-1:0]   h_rdata_o,
   output logic [NUM_REQ-1:0]              h_err_o,
   output logic                            m_req_o,
   input  logic                            m_gnt_i,
   output logic [ADDR_WIDTH-1:0]           m_addr_o,
   output logic                            m_we_o,
   output logic [DATA_WIDTH/8-1:0]         m_be_o,
   output logic [DATA_WIDTH-1:0]           m_wdata_o,
   input  logic                            m_rvalid_i,
   input  logic [DATA_WIDTH-1:0]           m_rdata_i,
   input  logic                            m_err_i,
   output logic                            unexp_rsp_o
);

   localparam int IDW = ID_W(NUM_REQ);
   localparam int BW  = DATA_WIDTH / 8;
   localparam logic [IDW-1:0] LAST = IDW'(NUM_REQ - 1);

   arb_state_e     state;
   logic [IDW-1:0] lock_idx;
   logic [IDW-1:0] rr_ptr;
   logic [IDW-1:0] pick;
   logic [IDW-1:0] sel;
   logic [IDW-1:0] head;
   logic           full;
   logic           empty;
   logic           hs;
   logic           pop;

   assign pick = IDW'(rr_pick(8'(h_req_i), 3'(rr_ptr)));
   assign sel  = (state == ARB_LOCKED) ? lock_idx : pick;

   // full is registered, so a same-cycle pop cannot reopen the request path.
   assign m_req_o = h_req_i[sel] & ~full;
   assign hs      = m_req_o & m_gnt_i;
   assign pop     = m_rvalid_i & ~empty;

   assign m_addr_o  = h_addr_i[int'(sel)*ADDR_WIDTH +: ADDR_WIDTH];
   assign m_we_o    = h_we_i[sel];
   assign m_be_o    = h_be_i[int'(sel)*BW +: BW];
   assign m_wdata_o = h_wdata_i[int'(sel)*DATA_WIDTH +: DATA_WIDTH];
   assign h_rdata_o = {NUM_REQ{m_rdata_i}};

   always_comb begin
      h_gnt_o    = '0;
      h_rvalid_o = '0;
      h_err_o    = '0;
      if (hs) h_gnt_o[sel] = 1'b1;
      if (pop) begin
         h_rvalid_o[head] = 1'b1;
         h_err_o[head]    = m_err_i;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ARB_IDLE;
         lock_idx    <= '0;
         unexp_rsp_o <= 1'b0;
      end else begin
         if (m_rvalid_i && empty) unexp_rsp_o <= 1'b1;
         if (hs) begin
            state <= ARB_IDLE;
         end else if (state == ARB_LOCKED) begin
            if (!h_req_i[lock_idx]) state <= ARB_IDLE;
         end else if (m_req_o) begin
            state    <= ARB_LOCKED;
            lock_idx <= sel;
         end
      end
   end

`ifdef IBEX_MEM_ARB_FIXED_PRIO_EN
   assign rr_ptr = '0;
`else
   always_ff @(posedge clk) begin
      if (reset) rr_ptr <= '0;
      else if (hs) rr_ptr <= (sel == LAST) ? '0 : sel + IDW'(1);
   end
`endif

   ibex_mem_arb_id_fifo #(
      .DEPTH(MAX_OUTSTANDING),
      .WIDTH(IDW)
   ) u_id_fifo (
      .clk  (clk),
      .reset(reset),
      .push (hs),
      .pop  (pop),
      .wdata(sel),
      .rdata(head),
      .full (full),
      .empty(empty)
   );

endmodule
